// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed program over a byte link,
// optionally verifies an XOR checksum, then serves the words to the CPU.
module imem_loader #(
  parameter logic [15:0] NOP_WORD = 16'h9000,
  parameter bit          CSUM_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  output logic        cpu_start,
  output logic        cpu_enable,
  output logic [8:0]  word_count,
  output logic        load_err
);

  typedef enum logic [2:0] {
    WAIT_LEN  = 3'd0,
    RECV_HI   = 3'd1,
    RECV_LO   = 3'd2,
    RECV_CSUM = 3'd3,
    RUN       = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  hi_r, hi_s;
  logic [7:0]  csum_r, csum_s;
  logic [8:0]  wp_r, wp_s;
  logic [8:0]  n_r, n_s;
  logic [8:0]  wp_inc_s;
  logic        ready_s;
  logic        xfer_s;
  logic        mem_we_s;
  logic        run_entry_s;
  logic [15:0] mem [0:255];

  // Reload and reset both block the link so a concurrent byte is never consumed.
  assign ready_s  = !reload && !reset &&
                    ((state_r == WAIT_LEN) || (state_r == RECV_HI) ||
                     (state_r == RECV_LO)  || (state_r == RECV_CSUM));
  assign rx_ready = ready_s;
  assign xfer_s   = rx_valid && ready_s;
  assign wp_inc_s = wp_r + 9'd1;

  // Next-state and datapath updates for the receive sequence.
  always_comb begin
    state_s  = state_r;
    hi_s     = hi_r;
    csum_s   = csum_r;
    wp_s     = wp_r;
    n_s      = n_r;
    mem_we_s = 1'b0;
    if (reload) begin
      state_s = WAIT_LEN;
    end else begin
      case (state_r)
        WAIT_LEN: begin
          if (xfer_s) begin
            n_s     = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            wp_s    = 9'd0;
            csum_s  = 8'd0;
            state_s = RECV_HI;
          end else begin
            state_s = WAIT_LEN;
          end
        end
        RECV_HI: begin
          if (xfer_s) begin
            hi_s    = rx_data;
            csum_s  = csum_r ^ rx_data;
            state_s = RECV_LO;
          end else begin
            state_s = RECV_HI;
          end
        end
        RECV_LO: begin
          if (xfer_s) begin
            mem_we_s = 1'b1;
            csum_s   = csum_r ^ rx_data;
            wp_s     = wp_inc_s;
            if (wp_inc_s == n_r) begin
              state_s = CSUM_EN ? RECV_CSUM : RUN;
            end else begin
              state_s = RECV_HI;
            end
          end else begin
            state_s = RECV_LO;
          end
        end
        RECV_CSUM: begin
          if (xfer_s) begin
            state_s = (rx_data == csum_r) ? RUN : ERR;
          end else begin
            state_s = RECV_CSUM;
          end
        end
        RUN:     state_s = RUN;
        ERR:     state_s = ERR;
        default: state_s = WAIT_LEN;
      endcase
    end
  end

  assign run_entry_s = (state_s == RUN) && (state_r != RUN);

  // State, datapath and registered CPU-facing outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= WAIT_LEN;
      hi_r       <= 8'd0;
      csum_r     <= 8'd0;
      wp_r       <= 9'd0;
      n_r        <= 9'd0;
      word_count <= 9'd0;
      cpu_start  <= 1'b0;
      cpu_enable <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      hi_r       <= hi_s;
      csum_r     <= csum_s;
      wp_r       <= wp_s;
      n_r        <= n_s;
      cpu_start  <= run_entry_s;
      cpu_enable <= (state_s == RUN);
      load_err   <= (state_s == ERR);
      if (reload) begin
        word_count <= 9'd0;
      end else if (run_entry_s) begin
        word_count <= n_r;
      end else begin
        word_count <= word_count;
      end
    end
  end

  // Program RAM write port; contents survive reset and reload.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem[wp_r[7:0]] <= {hi_r, rx_data};
    end
  end

  // Words beyond the loaded length, or outside RUN, read as NOP.
  assign i_datain = ((state_r == RUN) && ({1'b0, i_addr} < word_count)) ?
                    mem[i_addr] : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized program loads compared against
// an array-based model of the expected RAM image, checksum and CPU handshake.
module tb_imem_loader;

  localparam logic [15:0] NOP = 16'h9000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic [7:0]  i_addr = 8'd0;
  logic [15:0] i_datain;
  logic        cpu_start;
  logic        cpu_enable;
  logic [8:0]  word_count;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_mem [256];

  imem_loader #(.NOP_WORD(16'h9000), .CSUM_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .i_addr(i_addr), .i_datain(i_datain),
    .cpu_start(cpu_start), .cpu_enable(cpu_enable), .word_count(word_count),
    .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    while (!rx_ready && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    n_cmp++;
    if (rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  // Verify the outcome of a finished load against the model.
  task automatic check_after(input int n, input bit bad);
    logic [15:0] exp;
    @(negedge clock);
    if (!bad) begin
      n_cmp += 5;
      if (cpu_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b required 1", cpu_start); end
      if (cpu_enable !== 1'b1) begin n_err++; $display("FAIL run_enable: got %b required 1", cpu_enable); end
      if (word_count !== 9'(n)) begin n_err++; $display("FAIL word_count: got %0d required %0d", word_count, n); end
      if (load_err !== 1'b0) begin n_err++; $display("FAIL run_err: got %b required 0", load_err); end
      if (rx_ready !== 1'b0) begin n_err++; $display("FAIL run_ready: got %b required 0", rx_ready); end
      for (int a = 0; a < 256; a++) begin
        @(negedge clock);
        i_addr = 8'(a);
        #1;
        exp = (a < n) ? exp_mem[a] : NOP;
        n_cmp++;
        if (i_datain !== exp) begin
          n_err++;
          $display("FAIL read addr=%0d: got %h required %h", a, i_datain, exp);
        end
      end
      n_cmp += 2;
      if (cpu_start !== 1'b0) begin n_err++; $display("FAIL start_once: got %b required 0", cpu_start); end
      if (cpu_enable !== 1'b1) begin n_err++; $display("FAIL run_hold: got %b required 1", cpu_enable); end
    end else begin
      n_cmp += 4;
      if (load_err !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b required 1", load_err); end
      if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL err_enable: got %b required 0", cpu_enable); end
      if (cpu_start !== 1'b0) begin n_err++; $display("FAIL err_start: got %b required 0", cpu_start); end
      if (rx_ready !== 1'b0) begin n_err++; $display("FAIL err_ready: got %b required 0", rx_ready); end
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        i_addr = 8'($urandom_range(0, 255));
        #1;
        n_cmp++;
        if (i_datain !== NOP) begin
          n_err++;
          $display("FAIL err_read addr=%0d: got %h required %h", i_addr, i_datain, NOP);
        end
      end
    end
  endtask

  // Stream exp_mem[0..N-1] with a length byte and checksum (xor-ed with delta).
  task automatic run_load(input logic [7:0] len, input logic [7:0] delta, input int gap_mode);
    int n;
    logic [7:0] cs;
    n  = (len == 8'd0) ? 256 : int'(len);
    cs = 8'd0;
    send_byte(len, (gap_mode < 0) ? $urandom_range(0, 2) : gap_mode);
    for (int i = 0; i < n; i++) begin
      send_byte(exp_mem[i][15:8], (gap_mode < 0) ? $urandom_range(0, 2) : gap_mode);
      send_byte(exp_mem[i][7:0],  (gap_mode < 0) ? $urandom_range(0, 2) : gap_mode);
      cs = cs ^ exp_mem[i][15:8] ^ exp_mem[i][7:0];
    end
    send_byte(cs ^ delta, (gap_mode < 0) ? $urandom_range(0, 2) : gap_mode);
    check_after(n, delta != 8'd0);
  endtask

  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    #1;
    n_cmp++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reload_ready: got %b required 0", rx_ready); end
    @(negedge clock);
    reload = 1'b0;
    #1;
    n_cmp += 4;
    if (load_err !== 1'b0) begin n_err++; $display("FAIL reload_err: got %b required 0", load_err); end
    if (word_count !== 9'd0) begin n_err++; $display("FAIL reload_count: got %0d required 0", word_count); end
    if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL reload_enable: got %b required 0", cpu_enable); end
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reload_wait: got %b required 1", rx_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h07;
    repeat (2) @(negedge clock);
    n_cmp += 6;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b required 0", rx_ready); end
    if (cpu_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b required 0", cpu_start); end
    if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable: got %b required 0", cpu_enable); end
    if (word_count !== 9'd0) begin n_err++; $display("FAIL rst_count: got %0d required 0", word_count); end
    if (load_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", load_err); end
    if (i_datain !== NOP) begin n_err++; $display("FAIL rst_data: got %h required %h", i_datain, NOP); end
    reset = 1'b0;
    rx_valid = 1'b0;
    #1;
    n_cmp++;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_release: got %b required 1", rx_ready); end
  endtask

  task automatic test_basic();
    exp_mem[0] = 16'h1234;
    exp_mem[1] = 16'hABCD;
    run_load(8'h02, 8'h00, 0);
    do_reload();
  endtask

  task automatic test_csum_err();
    exp_mem[0] = 16'h1234;
    exp_mem[1] = 16'hABCD;
    run_load(8'h02, 8'h01, 0);
    do_reload();
  endtask

  task automatic test_full();
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'($urandom);
    run_load(8'h00, 8'h00, -1);
    do_reload();
  endtask

  task automatic test_toggle();
    exp_mem[0] = 16'h1234;
    exp_mem[1] = 16'hABCD;
    run_load(8'h02, 8'h00, 1);
    do_reload();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_mem[0] = 16'h0FF0;
    run_load(8'h01, 8'h00, 0);
    do_reload();
  endtask

  task automatic test_reload_run();
    exp_mem[0] = 16'($urandom);
    run_load(8'h01, 8'h00, 0);
    @(negedge clock);
    reload = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h05;
    i_addr = 8'h00;
    #1;
    n_cmp++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reload_vs_byte: got %b required 0", rx_ready); end
    @(negedge clock);
    reload = 1'b0;
    rx_valid = 1'b0;
    #1;
    n_cmp += 3;
    if (cpu_enable !== 1'b0) begin n_err++; $display("FAIL reload_drop: got %b required 0", cpu_enable); end
    if (word_count !== 9'd0) begin n_err++; $display("FAIL reload_wc: got %0d required 0", word_count); end
    if (i_datain !== NOP) begin n_err++; $display("FAIL reload_mask: got %h required %h", i_datain, NOP); end
    exp_mem[0] = 16'hAABB;
    run_load(8'h01, 8'h00, 0);
    do_reload();
  endtask

  task automatic test_random();
    int n;
    logic [7:0] delta;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) exp_mem[i] = 16'($urandom);
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_load(8'(n), delta, -1);
      do_reload();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_err();
    test_full();
    test_toggle();
    test_reset_mid();
    test_reload_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
